// File: rtl/rv_regfile_mp.sv
// Multi-port integer register file with issue scoreboard.
// x0 reads zero and is never busy; highest-index write port wins.
module rv_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NW-1:0]          wen,
  input  logic [NW*ADDR_W-1:0]   waddr,
  input  logic [NW*XLEN-1:0]     wdata,
  input  logic [NR*ADDR_W-1:0]   raddr,
  output logic [NR*XLEN-1:0]     rdata,
  output logic [NR-1:0]          rready,
  input  logic                   set_busy,
  input  logic [ADDR_W-1:0]      busy_addr,
  output logic [2**ADDR_W-1:0]   busy_vec,
  output logic                   wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             conf_q, conf_d;

  logic [NW-1:0]    wact;
  logic [ADDR_W-1:0] wa [NW];
  logic [XLEN-1:0]   wd [NW];

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      wa[i]   = waddr[i*ADDR_W +: ADDR_W];
      wd[i]   = wdata[i*XLEN +: XLEN];
      wact[i] = wen[i] && (wa[i] != '0);
    end
  end

  // Ascending scan: a later (higher) port overrides earlier matches.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [XLEN-1:0]   fwd;
    rdata  = '0;
    rready = '0;
    for (int j = 0; j < NR; j++) begin
      ra  = raddr[j*ADDR_W +: ADDR_W];
      hit = 1'b0;
      fwd = '0;
      for (int i = 0; i < NW; i++) begin
        if (wact[i] && wa[i] == ra) begin
          hit = 1'b1;
          fwd = wd[i];
        end
      end
      if (ra == '0) begin
        rdata[j*XLEN +: XLEN] = '0;
        rready[j]             = 1'b1;
      end else begin
        if (BYPASS != 0 && hit)
          rdata[j*XLEN +: XLEN] = fwd;
        else
          rdata[j*XLEN +: XLEN] = regs_q[ra];
        rready[j] = !busy_q[ra] || (BYPASS != 0 && hit);
      end
    end
  end

  // Set is applied after clear so a new producer replaces the old one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NW; i++)
      if (wact[i]) busy_d[wa[i]] = 1'b0;
    if (set_busy && busy_addr != '0)
      busy_d[busy_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    conf_d = 1'b0;
    for (int i = 0; i < NW; i++)
      for (int m = i + 1; m < NW; m++)
        if (wact[i] && wact[m] && wa[i] == wa[m])
          conf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        regs_q[k] <= '0;
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NW; i++)
        if (wact[i]) regs_q[wa[i]] <= wd[i];
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  assign busy_vec    = busy_q;
  assign wr_conflict = conf_q;

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Bench for rv_regfile_mp: bypass and non-bypass instances
// share stimulus and are checked against a behavioural model.
module tb_rv_regfile_mp;

  localparam int XL = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW-1:0]     wen;
  logic [NW*AW-1:0]  waddr;
  logic [NW*XL-1:0]  wdata;
  logic [NR*AW-1:0]  raddr;
  logic              set_busy;
  logic [AW-1:0]     busy_addr;

  logic [NR*XL-1:0]  rd_b, rd_n;
  logic [NR-1:0]     rr_b, rr_n;
  logic [31:0]       bv_b, bv_n;
  logic              wc_b, wc_n;

  logic [31:0] mregs [32];
  logic [31:0] mbusy;
  logic        mconf;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rv_regfile_mp #(.XLEN(XL), .ADDR_W(AW), .NR(NR), .NW(NW), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rd_b), .rready(rr_b), .set_busy(set_busy),
    .busy_addr(busy_addr), .busy_vec(bv_b), .wr_conflict(wc_b));

  rv_regfile_mp #(.XLEN(XL), .ADDR_W(AW), .NR(NR), .NW(NW), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rd_n), .rready(rr_n), .set_busy(set_busy),
    .busy_addr(busy_addr), .busy_vec(bv_n), .wr_conflict(wc_n));

  function automatic logic [4:0] rport(int j);
    return raddr[j*AW +: AW];
  endfunction

  function automatic logic [31:0] exp_rd(bit byp, int j);
    logic [4:0] a;
    a = rport(j);
    if (a == 0) return 32'h0;
    if (byp)
      for (int i = NW - 1; i >= 0; i--)
        if (wen[i] && waddr[i*AW +: AW] == a) return wdata[i*XL +: XL];
    return mregs[a];
  endfunction

  function automatic bit exp_rr(bit byp, int j);
    logic [4:0] a;
    a = rport(j);
    if (a == 0 || !mbusy[a]) return 1'b1;
    if (byp)
      for (int i = 0; i < NW; i++)
        if (wen[i] && waddr[i*AW +: AW] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mregs[k] = 32'h0;
    mbusy = 32'h0;
    mconf = 1'b0;
  endtask

  task automatic idle();
    wen      = '0;
    waddr    = '0;
    wdata    = '0;
    set_busy = 1'b0;
    busy_addr = '0;
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wen[p]             = 1'b1;
    waddr[p*AW +: AW]  = a;
    wdata[p*XL +: XL]  = d;
  endtask

  task automatic rdsel(int j, logic [4:0] a);
    raddr[j*AW +: AW] = a;
  endtask

  // Compute next model state from current inputs, then cross the edge.
  task automatic tick();
    logic [31:0] nr [32];
    logic [31:0] nb;
    int          cnt [32];
    bit          done [32];
    bit          nc;
    logic [4:0]  a;
    nr = mregs;
    nb = mbusy;
    nc = 1'b0;
    for (int k = 0; k < 32; k++) begin
      cnt[k]  = 0;
      done[k] = 1'b0;
    end
    for (int i = NW - 1; i >= 0; i--) begin
      a = waddr[i*AW +: AW];
      if (wen[i] && a != 0) begin
        cnt[a]++;
        if (!done[a]) nr[a] = wdata[i*XL +: XL];
        done[a] = 1'b1;
        nb[a]   = 1'b0;
      end
    end
    for (int k = 1; k < 32; k++) if (cnt[k] >= 2) nc = 1'b1;
    if (set_busy && busy_addr != 0) nb[busy_addr] = 1'b1;
    @(posedge clk);
    #1;
    if (!rst) begin
      mregs = nr;
      mbusy = nb;
      mconf = nc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    raddr = '0;
    rdsel(0, 5);
    model_reset();
    @(posedge clk); #1;
    vecs++;
    if (bv_b !== 32'h0 || wc_b !== 1'b0 || rd_b[31:0] !== 32'h0) begin
      errs++;
      $display("FAIL reset_state: busy=%h conf=%b rd=%h, want 0/0/0",
               bv_b, wc_b, rd_b[31:0]);
    end
    @(negedge clk);
    rst = 1'b0;
    wr(0, 5, 32'hDEADBEEF);
    set_busy  = 1'b1;
    busy_addr = 5'd6;
    tick();
    idle();
    vecs++;
    if (rd_n[31:0] !== 32'hDEADBEEF || bv_n !== mbusy) begin
      errs++;
      $display("FAIL reset_prewrite: rd=%h busy=%h, want DEADBEEF/%h",
               rd_n[31:0], bv_n, mbusy);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vecs++;
    if (rd_n[31:0] !== 32'h0 || rd_b[31:0] !== 32'h0 || bv_b !== 32'h0) begin
      errs++;
      $display("FAIL reset_async: rd=%h/%h busy=%h, want 0/0/0",
               rd_n[31:0], rd_b[31:0], bv_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_x0();
    idle();
    wr(0, 0, 32'hFFFFFFFF);
    wr(1, 0, 32'hFFFFFFFF);
    rdsel(0, 0);
    #1;
    vecs++;
    if (rd_b[31:0] !== 32'h0 || rr_b[0] !== 1'b1 || rd_n[31:0] !== 32'h0) begin
      errs++;
      $display("FAIL x0_read: rd=%h/%h rr=%b, want 0/0/1",
               rd_b[31:0], rd_n[31:0], rr_b[0]);
    end
    tick();
    idle();
    vecs++;
    if (wc_b !== 1'b0 || rd_n[31:0] !== 32'h0 || bv_b[0] !== 1'b0) begin
      errs++;
      $display("FAIL x0_conflict: conf=%b rd=%h, want 0/0", wc_b, rd_n[31:0]);
    end
  endtask

  task automatic test_priority();
    idle();
    wr(0, 3, 32'h11);
    wr(1, 3, 32'h22);
    rdsel(0, 3);
    tick();
    idle();
    vecs++;
    if (rd_n[31:0] !== 32'h22 || wc_b !== 1'b1 || wc_n !== 1'b1) begin
      errs++;
      $display("FAIL prio_conflict: rd=%h conf=%b/%b, want 22/1/1",
               rd_n[31:0], wc_b, wc_n);
    end
    tick();
    vecs++;
    if (wc_b !== 1'b0) begin
      errs++;
      $display("FAIL conflict_clear: got %b want 0", wc_b);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    idle();
    old = mregs[7];
    wr(1, 7, 32'h1234);
    rdsel(0, 7);
    rdsel(1, 7);
    #1;
    vecs++;
    if (rd_b[31:0] !== 32'h1234 || rd_b[63:32] !== 32'h1234) begin
      errs++;
      $display("FAIL bypass_same: got %h/%h want 1234", rd_b[31:0], rd_b[63:32]);
    end
    vecs++;
    if (rd_n[31:0] !== old) begin
      errs++;
      $display("FAIL nobypass_old: got %h want %h", rd_n[31:0], old);
    end
    tick();
    idle();
    vecs++;
    if (rd_n[31:0] !== 32'h1234) begin
      errs++;
      $display("FAIL nobypass_next: got %h want 1234", rd_n[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_busy  = 1'b1;
    busy_addr = 5'd9;
    tick();
    idle();
    rdsel(0, 9);
    #1;
    vecs++;
    if (bv_b[9] !== 1'b1 || rr_b[0] !== 1'b0 || rr_n[0] !== 1'b0) begin
      errs++;
      $display("FAIL sb_busy: bv9=%b rr=%b/%b, want 1/0/0",
               bv_b[9], rr_b[0], rr_n[0]);
    end
    wr(0, 9, 32'hA5A5_0009);
    #1;
    vecs++;
    if (rr_b[0] !== 1'b1 || rr_n[0] !== 1'b0) begin
      errs++;
      $display("FAIL sb_bypass_ready: rr=%b/%b, want 1/0", rr_b[0], rr_n[0]);
    end
    tick();
    idle();
    vecs++;
    if (bv_b[9] !== 1'b0 || rr_n[0] !== 1'b1) begin
      errs++;
      $display("FAIL sb_clear: bv9=%b rr=%b, want 0/1", bv_b[9], rr_n[0]);
    end
  endtask

  task automatic test_set_clear();
    idle();
    wr(0, 9, 32'hCAFE_F00D);
    set_busy  = 1'b1;
    busy_addr = 5'd9;
    rdsel(0, 9);
    tick();
    idle();
    vecs++;
    if (rd_n[31:0] !== 32'hCAFEF00D || bv_n[9] !== 1'b1) begin
      errs++;
      $display("FAIL set_over_clear: rd=%h bv9=%b, want CAFEF00D/1",
               rd_n[31:0], bv_n[9]);
    end
    set_busy  = 1'b1;
    busy_addr = 5'd0;
    tick();
    idle();
    vecs++;
    if (bv_b[0] !== 1'b0) begin
      errs++;
      $display("FAIL busy_x0: got %b want 0", bv_b[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NW; i++) begin
        wen[i] = ($urandom_range(0, 2) != 0);
        waddr[i*AW +: AW] = 5'($urandom_range(0, (n < 200) ? 7 : 31));
        wdata[i*XL +: XL] = $urandom;
      end
      for (int j = 0; j < NR; j++)
        raddr[j*AW +: AW] = 5'($urandom_range(0, (n < 200) ? 7 : 31));
      set_busy  = ($urandom_range(0, 1) != 0);
      busy_addr = 5'($urandom_range(0, (n < 200) ? 7 : 31));
      #1;
      for (int j = 0; j < NR; j++) begin
        vecs++;
        if (rd_b[j*XL +: XL] !== exp_rd(1'b1, j) ||
            rd_n[j*XL +: XL] !== exp_rd(1'b0, j)) begin
          errs++;
          $display("FAIL rand_rdata[%0d] n=%0d: got %h/%h want %h/%h", j, n,
                   rd_b[j*XL +: XL], rd_n[j*XL +: XL],
                   exp_rd(1'b1, j), exp_rd(1'b0, j));
        end
        vecs++;
        if (rr_b[j] !== exp_rr(1'b1, j) || rr_n[j] !== exp_rr(1'b0, j)) begin
          errs++;
          $display("FAIL rand_rready[%0d] n=%0d: got %b/%b want %b/%b", j, n,
                   rr_b[j], rr_n[j], exp_rr(1'b1, j), exp_rr(1'b0, j));
        end
      end
      vecs++;
      if (bv_b !== mbusy || bv_n !== mbusy ||
          wc_b !== mconf || wc_n !== mconf) begin
        errs++;
        $display("FAIL rand_state n=%0d: busy=%h/%h conf=%b/%b want %h/%b", n,
                 bv_b, bv_n, wc_b, wc_n, mbusy, mconf);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_priority();
    test_bypass();
    test_scoreboard();
    test_set_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
